// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions.
// Holds the FSM state encoding, the RV32 load/store funct3 codes and small
// helpers that decode access size, word crossing and request legality.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC1 = 2'd1,
    ST_ACC2 = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte-lane mask of an access at lane 0 (funct3[1:0] encodes the size).
  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    logic [3:0] m;
    case (funct3[1:0])
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // True when the access spills past byte 3 of its first word.
  function automatic logic crosses_word(input logic [1:0] off, input logic [2:0] funct3);
    logic [2:0] nbytes;
    case (funct3[1:0])
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    return (({1'b0, off} + nbytes) > 3'd4);
  endfunction

  // Illegal: not exactly one of read/write, reserved funct3, or unsigned store.
  function automatic logic is_illegal(input logic rd, input logic wr, input logic [2:0] funct3);
    logic bad;
    bad = (rd == wr);
    case (funct3)
      F3_B, F3_H, F3_W: bad = bad;
      F3_BU, F3_HU:     bad = bad | wr;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment and extension.
// Ports: lo   - first word read (holds the addressed byte at lane off)
//        hi   - low 3 bytes of the following word (0 when not read)
//        off  - byte offset of the access inside lo
//        funct3 - load type, selects size and sign/zero extension
//        rdata  - right-aligned, extended load result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] lo,
  input  logic [23:0] hi,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  logic [31:0] shifted_s;

  // Select the 4 bytes starting at off from the {hi,lo} byte stream.
  // A word at off 3 needs at most hi[23:0], so hi byte 3 is never kept.
  always_comb begin
    case (off)
      2'd0:    shifted_s = lo;
      2'd1:    shifted_s = {hi[7:0],  lo[31:8]};
      2'd2:    shifted_s = {hi[15:0], lo[31:16]};
      2'd3:    shifted_s = {hi[23:0], lo[31:24]};
      default: shifted_s = 32'd0;
    endcase
  end

  // Truncate to the access size and extend.
  always_comb begin
    case (funct3)
      F3_B:    rdata = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_BU:   rdata = {24'd0, shifted_s[7:0]};
      F3_H:    rdata = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_HU:   rdata = {16'd0, shifted_s[15:0]};
      F3_W:    rdata = shifted_s;
      default: rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit between EX/MEM and a word-addressed data memory.
// Converts one byte-addressed request into one or two word accesses with
// byte-lane masks, merges/extends load data, and holds busy for the stall.
// Ports: clk/rst (async active-high); req_* request handshake from EX/MEM;
//        resp_valid/resp_err/resp_rdata one-cycle completion; busy to the
//        hazard unit; mem_* word-indexed memory interface (combinational read).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int WIDTH      = 32,
  parameter int WORD_AW    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [WIDTH-1:0]      resp_rdata,
  output logic                  busy,
  output logic [WORD_AW-1:0]    mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [3:0]            mem_wmask,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata
);

  lsu_state_t          state_q, state_d;
  logic [WORD_AW+1:0]  addr_q, addr_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                load_q, load_d;
  logic                err_q, err_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic [23:0]         hi_q, hi_d;

  logic [7:0]          lane_mask_s;
  logic [2*WIDTH-1:0]  lane_data_s;
  logic [WIDTH-1:0]    align_rdata_s;
  logic [WORD_AW-1:0]  index_s;
  logic                unused_addr_bits;

  // Address bits above the memory's byte range are don't-care.
  assign unused_addr_bits = ^req_addr[ADDR_WIDTH-1:WORD_AW+2];

  assign index_s = addr_q[WORD_AW+1:2];
  // Lanes/data of the whole access as an 8-byte window; low half goes to
  // the first word, high half to the following word.
  assign lane_mask_s = 8'({4'b0000, size_mask(funct3_q)}) << addr_q[1:0];
  assign lane_data_s = {{WIDTH{1'b0}}, wdata_q} << {addr_q[1:0], 3'b000};

  lsu_load_align u_align (
    .lo     (lo_q),
    .hi     (hi_q),
    .off    (addr_q[1:0]),
    .funct3 (funct3_q),
    .rdata  (align_rdata_s)
  );

  // State and holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= 3'd0;
      load_q   <= 1'b0;
      err_q    <= 1'b0;
      lo_q     <= '0;
      hi_q     <= 24'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      load_q   <= load_d;
      err_q    <= err_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
    end
  end

  // Next-state and holding-register update.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    load_d   = load_q;
    err_d    = err_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr[WORD_AW+1:0];
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          load_d   = req_read;
          err_d    = is_illegal(req_read, req_write, req_funct3);
          lo_d     = '0;
          hi_d     = 24'd0;
          state_d  = is_illegal(req_read, req_write, req_funct3) ? ST_RESP : ST_ACC1;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_ACC1: begin
        if (load_q) begin
          lo_d = mem_rdata;
        end else begin
          lo_d = lo_q;
        end
        state_d = crosses_word(addr_q[1:0], funct3_q) ? ST_ACC2 : ST_RESP;
      end
      ST_ACC2: begin
        if (load_q) begin
          hi_d = mem_rdata[23:0];
        end else begin
          hi_d = hi_q;
        end
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state; mem_we follows state_q so
  // it falls as soon as rst asserts.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_addr   = '0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_wmask  = 4'b0000;
    mem_wdata  = '0;
    // Stall already in the accepting cycle so the pipeline holds the op.
    busy       = (state_q != ST_IDLE) || req_valid;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_ACC1: begin
        mem_addr = index_s;
        if (load_q) begin
          mem_re = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_wmask = lane_mask_s[3:0];
          mem_wdata = lane_data_s[WIDTH-1:0];
        end
      end
      ST_ACC2: begin
        // Index naturally wraps from DEPTH-1 to 0 in WORD_AW bits.
        mem_addr = index_s + {{(WORD_AW-1){1'b0}}, 1'b1};
        if (load_q) begin
          mem_re = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_wmask = lane_mask_s[7:4];
          mem_wdata = lane_data_s[2*WIDTH-1:WIDTH];
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (load_q && !err_q) begin
          resp_rdata = align_rdata_s;
        end else begin
          resp_rdata = '0;
        end
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits in the MEM stage between the EX/MEM pipeline register and the 64x32 data memory.
- Accepts one byte-addressed load/store request and converts it into word-indexed memory accesses with byte-lane masks.
- Splits a misaligned halfword/word into two word accesses, then merges and sign/zero-extends load data.
- Asserts busy so the hazard unit stalls the pipeline while an access is in flight.

Parameters:
- ADDR_WIDTH, 32, width of the byte address from EX/MEM.
- DEPTH, 64, data memory depth in words.
- WIDTH, 32, data word width. Fixed at 32; byte-lane logic assumes 4 lanes.
- WORD_AW, 6, word-index width; equals clog2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (IDLE only).
- req_read  in  1  load request.
- req_write  in  1  store request.
- req_addr  in  ADDR_WIDTH  byte address; bits above [WORD_AW+1:0] are ignored.
- req_wdata  in  WIDTH  store data, right-aligned.
- req_funct3  in  3  RV32 load/store funct3.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  request was illegal; qualified by resp_valid.
- resp_rdata  out  WIDTH  extended load result; 0 for stores and errors.
- busy  out  1  high from acceptance until resp_valid (inclusive).
- mem_addr  out  WORD_AW  word index to the data memory.
- mem_re  out  1  read strobe.
- mem_we  out  1  write strobe; memory writes on the clk edge.
- mem_wmask  out  4  byte-lane enables, bit i = byte i.
- mem_wdata  out  WIDTH  lane-aligned write data.
- mem_rdata  in  WIDTH  memory read data; combinational from mem_addr.

Behaviour:
- Reset: state IDLE, all outputs 0 except req_ready=1. Holding registers cleared.
- Reset mid-operation: mem_we drops immediately (asynchronous). An in-flight access is abandoned; no resp_valid is produced.
- FSM states: IDLE, ACC1, ACC2, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr/wdata/funct3/type and go to ACC1.
  - Illegal requests go directly to RESP with the error flag set and perform no memory access.
  - Illegal = funct3 in {011,110,111}; or a store with funct3 bit2 set; or both or neither of req_read/req_write.
- ACC1:
  - mem_addr = addr[WORD_AW+1:2].
  - Load: mem_re=1, capture mem_rdata into lo.
  - Store: mem_we=1, mem_wmask = size_mask << off, mem_wdata = wdata << (8*off). off = addr[1:0]; size_mask = 0001 / 0011 / 1111 for B/H/W.
  - Go to ACC2 if the access crosses a word (off + bytes > 4); otherwise go to RESP.
- ACC2:
  - mem_addr = (index + 1) mod DEPTH; index 63 wraps to 0.
  - Load: capture mem_rdata into hi.
  - Store: mem_wmask = size_mask >> (4 - off), mem_wdata = wdata >> (8*(4 - off)).
  - Go to RESP.
- RESP:
  - resp_valid=1 for one cycle, then return to IDLE. No request is accepted in RESP.
  - Load result: ({hi,lo} >> 8*off) truncated to the access size, then extended. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - hi is 0 when ACC2 was skipped.
- Latency (accept-edge cycle = 0): aligned access resp_valid in cycle 2; crossing access in cycle 3; error in cycle 1.
- Throughput: one request per 3 cycles (aligned) or 4 cycles (crossing).
- Byte accesses never cross a word boundary.
- mem_re and mem_we are never both high.

Decomposition:
- Package lsu_pkg holds:
  - state enum;
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - size_mask function;
  - crosses_word function.
- One sub-module, lsu_load_align: combinational merge/shift/extend of {hi,lo}, off and funct3 into resp_rdata.

Test Plan:
- Memory preload: word4=0x8899AABB, word5=0xCCDDEEFF.
- LW at 0x10 -> one read of word 4; resp_rdata=0x8899AABB; resp_valid at cycle 2; busy high cycles 0-2.
- LB at 0x13 -> 0xFFFFFF88. LBU at 0x13 -> 0x00000088. LHU at 0x12 -> 0x00008899.
- LW at 0x12 -> reads word 4 then word 5; resp_rdata=0xEEFF8899; resp_valid at cycle 3.
- SW 0xA5A5A5A5 at 0x16:
  - ACC1: word5, mask 1100, wdata 0xA5A50000.
  - ACC2: word6, mask 0011, wdata 0x0000A5A5.
  - Readback LW 0x14 -> 0xA5A5EEFF.
- Wrap: LH at 0xFF -> ACC1 mem_addr=63, ACC2 mem_addr=0. Word63 byte3=0x12 and word0 byte0=0x80 give resp_rdata=0xFFFF8012.
- funct3=011 load -> resp_valid at cycle 1 with resp_err=1, resp_rdata=0, mem_re/mem_we never asserted.
- Reset during ACC2 of the crossing store -> mem_we low immediately, no resp_valid, req_ready=1 after release.
